// File: rtl/regbank.sv
// rtl/regbank.sv - parametrised CSR bank with RW, RO and W1C registers behind a req/ack bus port
module regbank #(
  parameter int              DATAW    = 32,
  parameter int              NREGS    = 8,
  parameter int              ADDRW    = 8,
  parameter logic [NREGS-1:0] RO_MASK  = '0,
  parameter logic [NREGS-1:0] W1C_MASK = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [ADDRW-1:0]       i_addr,
  input  logic [DATAW/8-1:0]     i_be,
  input  logic [DATAW-1:0]       i_data,
  output logic                   o_ack,
  output logic                   o_err,
  output logic [DATAW-1:0]       o_data,
  input  logic [NREGS*DATAW-1:0] i_hw_ro,
  input  logic [NREGS*DATAW-1:0] i_hw_set,
  output logic [NREGS*DATAW-1:0] o_regs,
  output logic [NREGS-1:0]       o_wr_stb
);
  localparam int NB = DATAW / 8;

  logic [NREGS-1:0][DATAW-1:0] cur;
  logic [NREGS-1:0]            wr_hit;
  logic [DATAW-1:0]            bemask;
  logic [DATAW-1:0]            rd_val;
  logic                        in_range;
  logic                        wr_req;

  always_comb begin
    bemask = '0;
    for (int k = 0; k < NB; k++) begin
      bemask[k*8 +: 8] = {8{i_be[k]}};
    end
  end

  // One extra bit so NREGS == 2**ADDRW still compares correctly
  assign in_range = ({1'b0, i_addr} < (ADDRW+1)'(NREGS));
  assign wr_req   = i_req && i_we && in_range && (|i_be);

  for (genvar n = 0; n < NREGS; n++) begin : g_reg
    if (RO_MASK[n]) begin : g_ro
      logic unused_set;
      assign unused_set = ^i_hw_set[n*DATAW +: DATAW];
      assign cur[n]     = i_hw_ro[n*DATAW +: DATAW];
      assign wr_hit[n]  = 1'b0;
    end else if (W1C_MASK[n]) begin : g_w1c
      logic [DATAW-1:0] q;
      logic [DATAW-1:0] clr;
      logic             unused_ro;
      assign unused_ro = ^i_hw_ro[n*DATAW +: DATAW];
      assign wr_hit[n] = wr_req && (i_addr == ADDRW'(n));
      assign clr       = wr_hit[n] ? (i_data & bemask) : '0;
      // Hardware set is OR'd in after the clear so it wins on a collision
      always_ff @(posedge i_clk) begin
        if (i_rst) q <= '0;
        else       q <= (q & ~clr) | i_hw_set[n*DATAW +: DATAW];
      end
      assign cur[n] = q;
    end else begin : g_rw
      logic [DATAW-1:0] q;
      logic             unused_hw;
      assign unused_hw = ^{i_hw_ro[n*DATAW +: DATAW], i_hw_set[n*DATAW +: DATAW]};
      assign wr_hit[n] = wr_req && (i_addr == ADDRW'(n));
      always_ff @(posedge i_clk) begin
        if (i_rst)          q <= '0;
        else if (wr_hit[n]) q <= (q & ~bemask) | (i_data & bemask);
      end
      assign cur[n] = q;
    end
    assign o_regs[n*DATAW +: DATAW] = cur[n];
  end

  always_comb begin
    rd_val = '0;
    for (int n = 0; n < NREGS; n++) begin
      if (i_addr == ADDRW'(n)) rd_val = cur[n];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ack    <= 1'b0;
      o_err    <= 1'b0;
      o_data   <= '0;
      o_wr_stb <= '0;
    end else begin
      o_ack    <= i_req;
      o_err    <= i_req && !in_range;
      o_wr_stb <= wr_hit;
      if (i_req && !in_range)  o_data <= '0;
      else if (i_req && !i_we) o_data <= rd_val;
    end
  end
endmodule
